// File: rtl/sdram_amm_arb.sv
//------------------------------------------------------------------------------
// Module      : sdram_amm_arb
// Description : Two-requester Avalon-MM arbiter in front of the HPS SDRAM port.
//               Round-robin grant with atomic write bursts; read responses are
//               steered back to their issuer via an in-order tag FIFO.
//               Optional macro SDRAM_ARB_LCD_PRIO_EN: requester 0 (LCD DMA)
//               gets fixed priority instead of round-robin.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdram_amm_arb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int BURST_W   = 11,
    parameter int MAX_OUTST = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [2*ADDR_W-1:0]     m_address,
    input  logic [2*BURST_W-1:0]    m_burstcount,
    input  logic [1:0]              m_read,
    input  logic [1:0]              m_write,
    input  logic [2*DATA_W-1:0]     m_writedata,
    input  logic [2*DATA_W/8-1:0]   m_byteenable,
    output logic [1:0]              m_waitrequest,
    output logic [DATA_W-1:0]       m_readdata,
    output logic [1:0]              m_readdatavalid,
    output logic [ADDR_W-1:0]       s_address,
    output logic [BURST_W-1:0]      s_burstcount,
    output logic [DATA_W-1:0]       s_writedata,
    output logic [DATA_W/8-1:0]     s_byteenable,
    output logic                    s_read,
    output logic                    s_write,
    input  logic                    s_waitrequest,
    input  logic [DATA_W-1:0]       s_readdata,
    input  logic                    s_readdatavalid,
    output logic                    err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(MAX_OUTST);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WR_BURST = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_gnt_q, last_gnt_d;
    logic [BURST_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BURST_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic                 err_q, err_d;
    logic [PTR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q, rd_ptr_d;

    // Tag FIFO storage: issuing requester and effective burst length
    logic                 tag_id_q  [MAX_OUTST];
    logic [BURST_W-1:0]   tag_len_q [MAX_OUTST];

    logic                 w_full, w_empty;
    logic [1:0]           w_elig;
    logic                 w_win, w_owner, w_burst, w_active;
    logic                 w_own_wr, w_own_rd, w_gnt_ok;
    logic                 w_wr_acc, w_rd_acc, w_pop;
    logic [BURST_W-1:0]   w_own_bc, w_bc_eff;
    logic                 w_head_id;
    logic [BURST_W-1:0]   w_head_len;

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign w_head_id  = tag_id_q[rd_ptr_q[PTR_W-1:0]];
    assign w_head_len = tag_len_q[rd_ptr_q[PTR_W-1:0]];

    // Eligibility, arbitration winner and the resulting command-path owner
    always_comb begin
        w_elig[0] = m_write[0] | (m_read[0] & ~w_full);
        w_elig[1] = m_write[1] | (m_read[1] & ~w_full);
`ifdef SDRAM_ARB_LCD_PRIO_EN
        w_win = ~w_elig[0];
`else
        if (&w_elig) begin
            w_win = ~last_gnt_q;
        end else begin
            w_win = ~w_elig[0];
        end
`endif
        w_burst  = (state_q == ST_WR_BURST);
        w_owner  = w_burst ? owner_q : w_win;
        // Reset gates the strobes so nothing leaks to the SDRAM while held
        w_active = rst_n_i & (w_burst | (|w_elig));
        w_own_wr = w_owner ? m_write[1] : m_write[0];
        w_own_rd = w_owner ? m_read[1]  : m_read[0];
        w_own_bc = w_owner ? m_burstcount[2*BURST_W-1:BURST_W]
                           : m_burstcount[BURST_W-1:0];
        w_bc_eff = (w_own_bc == '0) ? BURST_W'(1) : w_own_bc;
    end

    assign s_write  = w_active & w_own_wr;
    assign s_read   = w_active & ~w_burst & ~w_own_wr & w_own_rd & ~w_full;
    assign w_gnt_ok = w_active & ~s_waitrequest;
    assign w_wr_acc = s_write & ~s_waitrequest;
    assign w_rd_acc = s_read & ~s_waitrequest;

    assign m_waitrequest[0] = ~(w_gnt_ok & ~w_owner);
    assign m_waitrequest[1] = ~(w_gnt_ok &  w_owner);

    assign s_address    = w_owner ? m_address[2*ADDR_W-1:ADDR_W]  : m_address[ADDR_W-1:0];
    assign s_burstcount = w_own_bc;
    assign s_writedata  = w_owner ? m_writedata[2*DATA_W-1:DATA_W] : m_writedata[DATA_W-1:0];
    assign s_byteenable = w_owner ? m_byteenable[2*BE_W-1:BE_W]    : m_byteenable[BE_W-1:0];

    assign m_readdata         = s_readdata;
    assign m_readdatavalid[0] = ~w_empty & s_readdatavalid & ~w_head_id;
    assign m_readdatavalid[1] = ~w_empty & s_readdatavalid &  w_head_id;
    assign err_o              = err_q;

    // Next-state: burst lock FSM, round-robin pointer, tag FIFO and response counter
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        err_d      = err_q;
        w_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_wr_acc) begin
                    if (w_bc_eff > BURST_W'(1)) begin
                        state_d    = ST_WR_BURST;
                        owner_d    = w_owner;
                        beat_cnt_d = w_bc_eff - BURST_W'(1);
                    end else begin
                        last_gnt_d = w_owner;
                    end
                end else if (w_rd_acc) begin
                    last_gnt_d = w_owner;
                end
            end
            ST_WR_BURST: begin
                if (w_wr_acc) begin
                    beat_cnt_d = beat_cnt_q - BURST_W'(1);
                    if (beat_cnt_q == BURST_W'(1)) begin
                        state_d    = ST_IDLE;
                        last_gnt_d = owner_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_rd_acc) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end

        if (s_readdatavalid) begin
            if (w_empty) begin
                err_d = 1'b1;
            end else if (rd_cnt_q + BURST_W'(1) == w_head_len) begin
                w_pop    = 1'b1;
                rd_cnt_d = '0;
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            end else begin
                rd_cnt_d = rd_cnt_q + BURST_W'(1);
            end
        end
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            beat_cnt_q <= '0;
            rd_cnt_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    // Tag FIFO payload write; validity is tracked solely by the pointers
    always_ff @(posedge clk_i) begin
        if (w_rd_acc) begin
            tag_id_q[wr_ptr_q[PTR_W-1:0]]  <= w_owner;
            tag_len_q[wr_ptr_q[PTR_W-1:0]] <= w_bc_eff;
        end
    end

endmodule

`default_nettype wire
